mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage; consumes the EX/MEM pipeline register and issues loads/stores to data memory over a req/gnt/rvalid handshake.
- Aligns store data and byte enables, and sign/zero-extends load data.
- Produces the registered MEM/WB pipeline register.
- Stalls the front of the pipe while a data-memory access is outstanding.

Parameters:
None. The data path is fixed at 32 bits by PipeTypes.svh.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_mem_i  in  1  downstream stall; hold mem_wb_o
flush_mem_i  in  1  kill instruction currently in MEM
ex_mem_i  in  EX_MEM_t  uses valid, pc, alu_res (address/result), rs2_data, rd, ctrl.mem_read, ctrl.mem_write, ctrl.mem_size (funct3), ctrl.reg_write
mem_wb_o  out  MEM_WB_t  valid, pc, rd, alu_res, load_data, ctrl
stall_mem_o  out  1  MEM busy; upstream must hold ex_mem_i
misalign_o  out  1  registered one-cycle pulse on misaligned access
misalign_addr_o  out  32  faulting address, valid with misalign_o
dmem_req_o  out  1  request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  32  {alu_res[31:2],2'b00}
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  response (load data or store ack), one per granted request
dmem_rdata_i  in  32  load data

Behaviour:
- Reset values: mem_wb_o = '0, misalign_o = 0, misalign_addr_o = 0, state = IDLE, all dmem outputs 0.
- A "mem op" is ex_mem_i.valid & (mem_read | mem_write).
- Misalignment:
  - Halfword with addr[0] = 1 is misaligned.
  - Word with addr[1:0] != 0 is misaligned.
  - A misaligned op issues no bus request and does not stall.
  - Next edge: misalign_o = 1, misalign_addr_o = alu_res, mem_wb_o.valid = 0.
- Stores:
  - SB: be = 1 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
- Loads:
  - be = 1111.
  - Select the lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - funct3 encodings: 000, 001, 010, 100, 101.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID, HOLD.
  - IDLE: on an aligned mem op with !flush_mem_i, drive dmem_req_o combinationally in the same cycle and latch the request fields.
    - gnt = 1 -> WAIT_RVALID.
    - gnt = 0 -> WAIT_GNT.
  - WAIT_GNT: keep req, addr, we, be and wdata stable until gnt, then -> WAIT_RVALID. A request is never retracted.
  - WAIT_RVALID: on rvalid, compute the result.
    - stall_mem_i = 0: write mem_wb_o at this edge -> IDLE.
    - stall_mem_i = 1: capture the result internally -> HOLD.
  - HOLD: when stall_mem_i falls, write mem_wb_o -> IDLE.
- stall_mem_o = mem op pending and not completing this cycle.
  - It is high in IDLE-with-mem-op, WAIT_GNT and HOLD, and in WAIT_RVALID until rvalid.
  - Best case (gnt in cycle 0, rvalid in cycle 1): access takes 2 cycles, stall_mem_o high for exactly 1 cycle.
- Non-memory instructions: mem_wb_o <= ex_mem_i fields (load_data = 0) on the next edge; no stall.
- stall_mem_i = 1 with no completion pending: mem_wb_o holds.
- flush_mem_i:
  - In IDLE: suppress any new request; mem_wb_o.valid <= 0.
  - While a transaction is outstanding: set an internal kill flag. The bus transaction still completes; on completion mem_wb_o.valid = 0 and the kill flag clears.
- Both stall_mem_i and flush_mem_i asserted: flush wins.
- Reset mid-transaction: state returns to IDLE immediately. A stale rvalid arriving in IDLE is ignored.
- mem_wb_o.ctrl.reg_write is forced to 0 for stores and killed ops.

Test Plan:
1. LW at 0x100, gnt in the same cycle, rvalid next cycle with rdata 0xDEADBEEF -> stall_mem_o high 1 cycle; mem_wb_o.load_data = 0xDEADBEEF, valid = 1.
2. LB at 0x103 with rdata 0x80FF_0000 -> load_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
3. SH at 0x202 with rs2 0x1234ABCD -> dmem_be_o = 1100, dmem_wdata_o = 0xABCDABCD, dmem_we_o = 1, dmem_addr_o = 0x200.
4. LW at 0x101 -> no dmem_req_o; misalign_o pulses one cycle with misalign_addr_o = 0x101; mem_wb_o.valid = 0.
5. Grant delayed 3 cycles and rvalid delayed 2 further cycles -> dmem_req_o and dmem_addr_o stable throughout; stall_mem_o high 5 cycles.
6. stall_mem_i held during rvalid, then released after 2 cycles -> FSM enters HOLD and mem_wb_o updates on release. Separately, flush_mem_i in WAIT_RVALID -> bus completes and mem_wb_o.valid = 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register -> data-memory req/gnt/rvalid handshake -> registered MEM/WB.
// state       | meaning
// IDLE        | no access outstanding; aligned mem op issues its request combinationally
// WAIT_GNT    | request presented, waiting for grant; bus fields held stable
// WAIT_RVALID | request granted, waiting for the response
// HOLD        | response received while downstream stalled; result parked in hold_q

package mem_stage_pkg;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } EX_MEM_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] load_data;
    ctrl_t       ctrl;
  } MEM_WB_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_mem_i,
  input  logic        flush_mem_i,
  input  EX_MEM_t     ex_mem_i,
  output MEM_WB_t     mem_wb_o,
  output logic        stall_mem_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, HOLD} state_t;

  state_t  state_q, state_d;
  EX_MEM_t req_q, bus_src;
  MEM_WB_t mem_wb_q, hold_q, wb_d, result;
  logic    kill_q, kill_d;
  logic    wb_we, hold_we, latch_req, bus_en;
  logic    mem_op, misaligned, misalign_evt;

  function automatic logic misaligned_f(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] a, input logic [1:0] sz, input logic we);
    if (!we) return 4'hF;
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [31:0] d, input logic [1:0] sz, input logic we);
    if (!we) return '0;
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_f(input logic [31:0] rdata, input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [31:0] sh;
    sh = rdata >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign mem_op       = ex_mem_i.valid & (ex_mem_i.ctrl.mem_read | ex_mem_i.ctrl.mem_write);
  assign misaligned   = misaligned_f(ex_mem_i.alu_res[1:0], ex_mem_i.ctrl.mem_size[1:0]);
  assign misalign_evt = (state_q == IDLE) & mem_op & misaligned & ~flush_mem_i;
  assign mem_wb_o     = mem_wb_q;

  // A flush arriving on the completion cycle kills the result just like an earlier one.
  always_comb begin
    result                = '0;
    result.valid          = req_q.valid & ~kill_q & ~flush_mem_i;
    result.pc             = req_q.pc;
    result.rd             = req_q.rd;
    result.alu_res        = req_q.alu_res;
    result.ctrl           = req_q.ctrl;
    result.ctrl.reg_write = req_q.ctrl.reg_write & ~req_q.ctrl.mem_write & result.valid;
    result.load_data      = req_q.ctrl.mem_write ? 32'h0 :
                            load_f(dmem_rdata_i, req_q.alu_res[1:0], req_q.ctrl.mem_size);
  end

  always_comb begin
    state_d             = state_q;
    kill_d              = kill_q;
    latch_req           = 1'b0;
    hold_we             = 1'b0;
    wb_we               = 1'b0;
    wb_d                = mem_wb_q;
    wb_d.valid          = 1'b0;
    wb_d.ctrl.reg_write = 1'b0;
    stall_mem_o         = 1'b0;
    dmem_req_o          = 1'b0;
    bus_en              = 1'b0;
    bus_src             = req_q;
    dmem_we_o           = 1'b0;
    dmem_addr_o         = '0;
    dmem_be_o           = '0;
    dmem_wdata_o        = '0;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (flush_mem_i) begin
          wb_we = 1'b1;
        end else if (mem_op && !misaligned && !rst) begin
          bus_src     = ex_mem_i;
          bus_en      = 1'b1;
          dmem_req_o  = 1'b1;
          stall_mem_o = 1'b1;
          latch_req   = 1'b1;
          wb_we       = ~stall_mem_i;
          state_d     = dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else if (mem_op) begin
          wb_we = ~stall_mem_i;
        end else if (!stall_mem_i) begin
          wb_we          = 1'b1;
          wb_d.valid     = ex_mem_i.valid;
          wb_d.pc        = ex_mem_i.pc;
          wb_d.rd        = ex_mem_i.rd;
          wb_d.alu_res   = ex_mem_i.alu_res;
          wb_d.load_data = '0;
          wb_d.ctrl      = ex_mem_i.ctrl;
        end
      end
      WAIT_GNT: begin
        bus_en      = 1'b1;
        dmem_req_o  = 1'b1;
        stall_mem_o = 1'b1;
        wb_we       = ~stall_mem_i;
        if (flush_mem_i) kill_d = 1'b1;
        if (dmem_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        bus_en = 1'b1;
        if (dmem_rvalid_i) begin
          kill_d = 1'b0;
          if (flush_mem_i || !stall_mem_i) begin
            wb_we   = 1'b1;
            wb_d    = result;
            state_d = IDLE;
          end else begin
            hold_we     = 1'b1;
            stall_mem_o = 1'b1;
            state_d     = HOLD;
          end
        end else begin
          stall_mem_o = 1'b1;
          wb_we       = ~stall_mem_i;
          if (flush_mem_i) kill_d = 1'b1;
        end
      end
      HOLD: begin
        bus_en = 1'b1;
        if (flush_mem_i) begin
          wb_we               = 1'b1;
          wb_d                = hold_q;
          wb_d.valid          = 1'b0;
          wb_d.ctrl.reg_write = 1'b0;
          state_d             = IDLE;
        end else if (!stall_mem_i) begin
          wb_we   = 1'b1;
          wb_d    = hold_q;
          state_d = IDLE;
        end else begin
          stall_mem_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus_en) begin
      dmem_we_o    = bus_src.ctrl.mem_write;
      dmem_addr_o  = {bus_src.alu_res[31:2], 2'b00};
      dmem_be_o    = be_f(bus_src.alu_res[1:0], bus_src.ctrl.mem_size[1:0], bus_src.ctrl.mem_write);
      dmem_wdata_o = wdata_f(bus_src.rs2_data, bus_src.ctrl.mem_size[1:0], bus_src.ctrl.mem_write);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      kill_q          <= 1'b0;
      req_q           <= '0;
      hold_q          <= '0;
      mem_wb_q        <= '0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      misalign_o <= misalign_evt;
      if (latch_req)    req_q           <= ex_mem_i;
      if (hold_we)      hold_q          <= result;
      if (wb_we)        mem_wb_q        <= wb_d;
      if (misalign_evt) misalign_addr_o <= ex_mem_i.alu_res;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written corner sequences, and randomized
// accesses checked against an arithmetic reference model with a scripted memory responder.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem_i, flush_mem_i;
  EX_MEM_t     ex_mem_i;
  MEM_WB_t     mem_wb_o;
  logic        stall_mem_o, misalign_o;
  logic [31:0] misalign_addr_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall_mem_i(stall_mem_i), .flush_mem_i(flush_mem_i),
    .ex_mem_i(ex_mem_i), .mem_wb_o(mem_wb_o), .stall_mem_o(stall_mem_o),
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off,
                                           input logic [2:0] f3);
    longint full, span, v;
    int sz;
    sz   = size_bytes(f3);
    full = rdata;
    span = 64'd1 << (8 * sz);
    v    = (full >> (8 * off)) % span;
    if (!f3[2] && sz < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off, input bit st);
    int m;
    if (!st) return 4'hF;
    m = ((1 << size_bytes(f3)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] b, h;
    b = {24'h0, rs2[7:0]};
    h = {16'h0, rs2[15:0]};
    case (size_bytes(f3))
      1:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic EX_MEM_t make_ex(input logic [2:0] f3, input bit st, input logic [31:0] addr,
                                      input logic [31:0] rs2, input logic [31:0] pc);
    EX_MEM_t e;
    e = '0;
    e.valid = 1'b1;
    e.pc = pc;
    e.alu_res = addr;
    e.rs2_data = rs2;
    e.rd = 5'd9;
    e.ctrl.mem_read = !st;
    e.ctrl.mem_write = st;
    e.ctrl.mem_size = f3;
    e.ctrl.reg_write = 1'b1;
    return e;
  endfunction

  task automatic idle_inputs();
    ex_mem_i = '0;
    stall_mem_i = 1'b0;
    flush_mem_i = 1'b0;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = $urandom;
  endtask

  // Scripted responder: gnt at cycle gd, rvalid rdl cycles later, downstream stall held for
  // hold_n cycles starting at the rvalid cycle, optional flush at cycle fl_at.
  task automatic run_access(input EX_MEM_t e, input int gd, input int rdl, input logic [31:0] rdata,
                            input int hold_n, input int fl_at, input logic [3:0] xbe,
                            input logic [31:0] xwd, input logic [31:0] xld);
    int rv, comp, scnt;
    bit xvalid;
    logic [31:0] xaddr;
    rv = gd + rdl;
    comp = rv + hold_n;
    scnt = 0;
    xvalid = (fl_at < 0);
    xaddr = e.alu_res & 32'hFFFF_FFFC;
    ex_mem_i = e;
    for (int c = 0; c <= comp; c++) begin
      dmem_gnt_i = (c == gd);
      dmem_rvalid_i = (c == rv);
      dmem_rdata_i = (c == rv) ? rdata : $urandom;
      stall_mem_i = (hold_n > 0) && (c >= rv) && (c < comp);
      flush_mem_i = (c == fl_at);
      #1;
      chk("req_window", dmem_req_o, c <= gd);
      if (dmem_req_o) begin
        chk("bus_addr", dmem_addr_o, xaddr);
        chk("bus_we", dmem_we_o, e.ctrl.mem_write);
        chk("bus_be", dmem_be_o, xbe);
        if (e.ctrl.mem_write) chk("bus_wdata", dmem_wdata_o, xwd);
      end
      if (c == comp) chk("stall_at_completion", stall_mem_o, 1'b0);
      else if (stall_mem_o) scnt++;
      if (hold_n > 0 && c == comp) chk("hold_wb_not_early", mem_wb_o.valid, 1'b0);
      @(posedge clk); #1;
    end
    idle_inputs();
    if (hold_n == 0) chk("stall_cycles", scnt, rv);
    chk("wb_valid", mem_wb_o.valid, xvalid);
    chk("wb_reg_write", mem_wb_o.ctrl.reg_write, xvalid && !e.ctrl.mem_write);
    if (xvalid) begin
      chk("wb_pc", mem_wb_o.pc, e.pc);
      chk("wb_load_data", mem_wb_o.load_data, xld);
    end
  endtask

  task automatic run_nonmem(input EX_MEM_t e);
    ex_mem_i = e;
    #1;
    chk("nonmem_stall", stall_mem_o, 1'b0);
    chk("nonmem_req", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    chk("nonmem_valid", mem_wb_o.valid, e.valid);
    chk("nonmem_pc", mem_wb_o.pc, e.pc);
    chk("nonmem_alu", mem_wb_o.alu_res, e.alu_res);
    chk("nonmem_rd", mem_wb_o.rd, e.rd);
    chk("nonmem_ld", mem_wb_o.load_data, 32'h0);
    chk("nonmem_rw", mem_wb_o.ctrl.reg_write, e.ctrl.reg_write);
    ex_mem_i = '0;
  endtask

  task automatic run_misalign(input EX_MEM_t e);
    ex_mem_i = e;
    #1;
    chk("misal_no_req", dmem_req_o, 1'b0);
    chk("misal_no_stall", stall_mem_o, 1'b0);
    @(posedge clk); #1;
    chk("misal_pulse", misalign_o, 1'b1);
    chk("misal_addr", misalign_addr_o, e.alu_res);
    chk("misal_wb_valid", mem_wb_o.valid, 1'b0);
    ex_mem_i = '0;
    @(posedge clk); #1;
    chk("misal_pulse_end", misalign_o, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        st;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    int          gd;
    int          rdl;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    EX_MEM_t e, a, b;
    vecs[0]  = '{3'b010, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF,    32'h0,        32'hDEADBEEF, 0, 1};
    vecs[1]  = '{3'b000, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 4'hF,    32'h0,        32'hFFFFFF80, 0, 1};
    vecs[2]  = '{3'b100, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 4'hF,    32'h0,        32'h00000080, 0, 1};
    vecs[3]  = '{3'b101, 1'b0, 32'h102, 32'h0,        32'h80FF0000, 4'hF,    32'h0,        32'h000080FF, 0, 1};
    vecs[4]  = '{3'b001, 1'b0, 32'h102, 32'h0,        32'h80FF0000, 4'hF,    32'h0,        32'hFFFF80FF, 0, 1};
    vecs[5]  = '{3'b000, 1'b0, 32'h101, 32'h0,        32'h00007F00, 4'hF,    32'h0,        32'h0000007F, 1, 1};
    vecs[6]  = '{3'b001, 1'b1, 32'h202, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        0, 1};
    vecs[7]  = '{3'b000, 1'b1, 32'h201, 32'h00000055, 32'h0,        4'b0010, 32'h55555555, 32'h0,        0, 2};
    vecs[8]  = '{3'b010, 1'b1, 32'h300, 32'hCAFEF00D, 32'h0,        4'hF,    32'hCAFEF00D, 32'h0,        2, 1};
    vecs[9]  = '{3'b010, 1'b0, 32'h400, 32'h0,        32'h01234567, 4'hF,    32'h0,        32'h01234567, 3, 2};
    vecs[10] = '{3'b001, 1'b1, 32'h200, 32'h0000BEEF, 32'h0,        4'b0011, 32'hBEEFBEEF, 32'h0,        1, 1};
    vecs[11] = '{3'b001, 1'b0, 32'h100, 32'h0,        32'h12348001, 4'hF,    32'h0,        32'hFFFF8001, 0, 3};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb", mem_wb_o, '0);
    chk("rst_misal", misalign_o, 1'b0);
    chk("rst_misal_addr", misalign_addr_o, 32'h0);
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_we", dmem_we_o, 1'b0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_be", dmem_be_o, 4'h0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_access(make_ex(vecs[i].f3, vecs[i].st, vecs[i].addr, vecs[i].rs2, 32'h1000 + 4 * i),
                 vecs[i].gd, vecs[i].rdl, vecs[i].rdata, 0, -1,
                 vecs[i].be, vecs[i].wdata, vecs[i].ld);

    run_misalign(make_ex(3'b010, 1'b0, 32'h101, 32'h0, 32'h2000));
    run_misalign(make_ex(3'b001, 1'b1, 32'h203, 32'h0, 32'h2004));

    // downstream stall across rvalid, released after two cycles
    run_access(make_ex(3'b010, 1'b0, 32'h500, 32'h0, 32'h3000), 0, 1, 32'hAABBCCDD, 2, -1,
               4'hF, 32'h0, 32'hAABBCCDD);
    // flush while waiting for rvalid, and while waiting for grant
    run_access(make_ex(3'b000, 1'b0, 32'h501, 32'h0, 32'h3004), 0, 3, 32'h11223344, 0, 1,
               4'hF, 32'h0, 32'h0);
    run_access(make_ex(3'b010, 1'b1, 32'h504, 32'h77, 32'h3008), 2, 1, 32'h0, 0, 1,
               4'hF, 32'h77, 32'h0);

    // stall with nothing pending holds mem_wb_o; flush beats stall
    a = '0; a.valid = 1'b1; a.pc = 32'h4000; a.alu_res = 32'h55; a.rd = 5'd3; a.ctrl.reg_write = 1'b1;
    b = a; b.pc = 32'h4004; b.alu_res = 32'h66;
    run_nonmem(a);
    ex_mem_i = b;
    stall_mem_i = 1'b1;
    @(posedge clk); #1;
    chk("stall_hold_pc", mem_wb_o.pc, 32'h4000);
    chk("stall_hold_valid", mem_wb_o.valid, 1'b1);
    flush_mem_i = 1'b1;
    @(posedge clk); #1;
    chk("flush_over_stall", mem_wb_o.valid, 1'b0);
    idle_inputs();
    run_nonmem(b);

    // reset mid-transaction; stale rvalid afterwards must be ignored
    ex_mem_i = make_ex(3'b010, 1'b0, 32'h600, 32'h0, 32'h5000);
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_wb", mem_wb_o, '0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hFEEDFACE;
    #1;
    chk("stale_rv_stall", stall_mem_o, 1'b0);
    chk("stale_rv_req", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    chk("stale_rv_ignored", mem_wb_o.valid, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      logic [2:0] ld_f3[5];
      logic [31:0] base, addr, rs2, rdata;
      bit st;
      int off, gd, rdl, hold_n, fl_at;
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      if ($urandom_range(0, 9) < 2) begin
        e = '0;
        e.valid = 1'b1;
        e.pc = $urandom;
        e.alu_res = $urandom;
        e.rd = 5'($urandom_range(0, 31));
        e.ctrl.reg_write = 1'($urandom_range(0, 1));
        run_nonmem(e);
      end else begin
        st = ($urandom_range(0, 2) == 0);
        f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
        case (size_bytes(f3))
          1:       off = $urandom_range(0, 3);
          2:       off = 2 * $urandom_range(0, 1);
          default: off = 0;
        endcase
        base = $urandom;
        addr = (base & 32'hFFFF_FFFC) | off;
        rs2 = $urandom;
        rdata = $urandom;
        gd = $urandom_range(0, 3);
        rdl = $urandom_range(1, 3);
        hold_n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        fl_at = (hold_n == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, gd + rdl) : -1;
        run_access(make_ex(f3, st, addr, rs2, $urandom), gd, rdl, rdata, hold_n, fl_at,
                   ref_be(f3, off, st), ref_wdata(f3, rs2),
                   st ? 32'h0 : ref_load(rdata, off, f3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
